// File: rtl/wb_arbiter_2m_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encoding,
// default bus widths and the stall counter width.
package wb_arbiter_2m_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_TIMEOUT    = 255;
  localparam int unsigned CNT_WIDTH      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    ERR  = 2'd3
  } state_t;

  function automatic logic is_grant(input state_t s);
    return (s == GNT0) || (s == GNT1);
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Stall counter for the owning master: counts strobed, un-acked slave cycles
// and flags when the next un-acked cycle would exceed the allowed budget.
module wb_timeout_counter
  import wb_arbiter_2m_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic s_stb,
  input  logic s_ack,
  output logic expired
);

  localparam logic [CNT_WIDTH-1:0] THRESHOLD = CNT_WIDTH'(TIMEOUT - 1);

  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    stall_d = stall_q;
    if (start || s_ack) begin
      stall_d = '0;
    end else if (active && s_stb && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  // An ack on the threshold cycle wins over the timeout.
  assign expired = active && !s_ack && (stall_q == THRESHOLD);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with round-robin on contention,
// combinational pass-through while granted, and a stall timeout that
// returns a one-cycle err to the owning master.
module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_adr,
  input  logic [DATA_WIDTH-1:0] m0_dat_w,
  output logic [DATA_WIDTH-1:0] m0_dat_r,
  output logic                  m0_ack,
  output logic                  m0_err,

  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_adr,
  input  logic [DATA_WIDTH-1:0] m1_dat_w,
  output logic [DATA_WIDTH-1:0] m1_dat_r,
  output logic                  m1_ack,
  output logic                  m1_err,

  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADDR_WIDTH-1:0] s_adr,
  output logic [DATA_WIDTH-1:0] s_dat_w,
  input  logic [DATA_WIDTH-1:0] s_dat_r,
  input  logic                  s_ack,

  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  timeout_count
);

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] timeout_count_q, timeout_count_d;
  logic                 grant_start;
  logic                 expired;

  // State register; outputs decode from state, so reset clears them at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_d = last_grant_q ? GNT0 : GNT1;
        else if (m0_cyc)      state_d = GNT0;
        else if (m1_cyc)      state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc)     state_d = IDLE;
        else if (expired) state_d = ERR;
      end
      GNT1: begin
        if (!m1_cyc)     state_d = IDLE;
        else if (expired) state_d = ERR;
      end
      ERR:  state_d = IDLE;
    endcase
  end

  assign grant_start = (state_q == IDLE) && is_grant(state_d);

  always_comb begin
    last_grant_d    = last_grant_q;
    timeout_count_d = timeout_count_q;
    if (grant_start) last_grant_d = (state_d == GNT1);
    if ((state_q == ERR) && (timeout_count_q != '1)) timeout_count_d = timeout_count_q + 1'b1;
  end

  // Output logic
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_w  = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_dat_r = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_dat_r = '0;
    grant    = 2'b00;
    unique case (state_q)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_w  = m0_dat_w;
        m0_ack   = s_ack;
        m0_dat_r = s_dat_r;
        grant    = 2'b01;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_w  = m1_dat_w;
        m1_ack   = s_ack;
        m1_dat_r = s_dat_r;
        grant    = 2'b10;
      end
      ERR: begin
        // last_grant still names the master that owned the timed-out cycle.
        if (last_grant_q) m1_err = 1'b1;
        else              m0_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign timeout_count = timeout_count_q;

  wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .start   (grant_start),
    .active  (is_grant(state_q)),
    .s_stb   (s_stb),
    .s_ack   (s_ack),
    .expired (expired)
  );

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: a bus-ownership model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_wb_arbiter_2m;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [15:0] m_adr  [2];
  logic [15:0] m_datw [2];
  logic [15:0] s_dat_r;
  logic        s_ack;

  logic [15:0] m0_dat_r, m1_dat_r, s_adr, s_dat_w;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [1:0]  grant;
  logic [7:0]  timeout_count;

  int n_checks = 0;
  int n_pass   = 0;
  int ack0_seen = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
    .m0_dat_w(m_datw[0]), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
    .m1_dat_w(m_datw[1]), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack),
    .grant(grant), .timeout_count(timeout_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: who owns the bus (-1 none), who is owed an err (-1 none),
  // the last master granted, stalled cycles in this grant, timeouts seen.
  int md_owner, md_err_to, md_last, md_wait, md_tcount;

  function automatic int pick(input logic [1:0] cyc, input int last);
    if (cyc == 2'b11) return 1 - last;
    return cyc[0] ? 0 : 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_owner <= -1; md_err_to <= -1; md_last <= 1; md_wait <= 0; md_tcount <= 0;
    end else if (md_err_to >= 0) begin
      md_err_to <= -1;
      if (md_tcount < 255) md_tcount <= md_tcount + 1;
    end else if (md_owner >= 0) begin
      if (!m_cyc[md_owner]) md_owner <= -1;
      else if (!s_ack && md_wait == TIMEOUT - 1) begin
        md_err_to <= md_owner;
        md_owner  <= -1;
      end else if (s_ack) md_wait <= 0;
      else if (m_stb[md_owner]) md_wait <= md_wait + 1;
    end else if (m_cyc != 2'b00) begin
      md_owner <= pick(m_cyc, md_last);
      md_last  <= pick(m_cyc, md_last);
      md_wait  <= 0;
    end
  end

  logic [1:0]  e_grant, e_ack, e_err;
  logic        e_cyc, e_stb, e_we;
  logic [15:0] e_adr, e_datw, e_datr0, e_datr1;

  always @(negedge clk) begin
    e_grant = 2'b00; e_ack = 2'b00; e_err = 2'b00;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0; e_datw = '0; e_datr0 = '0; e_datr1 = '0;
    if (md_owner >= 0) begin
      e_grant[md_owner] = 1'b1;
      e_ack[md_owner]   = s_ack;
      e_cyc  = m_cyc[md_owner];
      e_stb  = m_stb[md_owner];
      e_we   = m_we[md_owner];
      e_adr  = m_adr[md_owner];
      e_datw = m_datw[md_owner];
      if (md_owner == 0) e_datr0 = s_dat_r;
      else               e_datr1 = s_dat_r;
    end
    if (md_err_to >= 0) e_err[md_err_to] = 1'b1;
    check("grant",   grant,            e_grant);
    check("ack",     {m1_ack, m0_ack}, e_ack);
    check("err",     {m1_err, m0_err}, e_err);
    check("s_ctl",   {s_cyc, s_stb, s_we}, {e_cyc, e_stb, e_we});
    check("s_adr",   s_adr,   e_adr);
    check("s_dat_w", s_dat_w, e_datw);
    check("m0_dat_r", m0_dat_r, e_datr0);
    check("m1_dat_r", m1_dat_r, e_datr1);
    check("timeout_count", timeout_count, md_tcount);
    if (m0_ack) ack0_seen++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0;
  endtask

  logic [1:0] rr_exp [4];
  int ack_base;

  initial begin
    reset = 1'b0;
    release_all();
    m_adr[0] = '0; m_adr[1] = '0; m_datw[0] = '0; m_datw[1] = '0; s_dat_r = '0;
    #2;
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_tcount", timeout_count, 8'd0);
    tick(2);
    reset = 1'b1;
    tick();

    // Single master write, slave acks on the second granted cycle
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    m_adr[0] = 16'h0010; m_datw[0] = 16'hBEEF;
    ack_base = ack0_seen;
    tick();
    check("s1_grant", grant, 2'b01);
    check("s1_s_adr", s_adr, 16'h0010);
    check("s1_s_dat_w", s_dat_w, 16'hBEEF);
    check("s1_s_we", s_we, 1'b1);
    tick();
    s_ack = 1'b1; s_dat_r = 16'h1234;
    #1;
    check("s1_m0_ack", m0_ack, 1'b1);
    check("s1_m0_dat_r", m0_dat_r, 16'h1234);
    check("s1_m1_ack", m1_ack, 1'b0);
    tick();
    release_all();
    tick();
    check("s1_ack_pulses", ack0_seen - ack_base, 1);

    // Contention right after reset: m0 first, one dead cycle, then m1
    reset = 1'b0; #1; reset = 1'b1;
    tick();
    m_cyc = 2'b11; m_stb = 2'b11; m_adr[1] = 16'h0F00; m_datw[1] = 16'h5A5A;
    tick();
    check("s2_first", grant, 2'b01);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick();
    check("s2_dead", grant, 2'b00);
    tick();
    check("s2_second", grant, 2'b10);
    check("s2_s_adr", s_adr, 16'h0F00);
    s_ack = 1'b1;
    tick();
    release_all();
    tick();

    // Round-robin with both masters requesting throughout
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("s3_grant%0d", i), grant, rr_exp[i]);
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0; m_cyc[i % 2] = 1'b0; m_stb[i % 2] = 1'b0;
      tick();
      m_cyc[i % 2] = 1'b1; m_stb[i % 2] = 1'b1;
    end
    release_all();
    tick();

    // Timeout: slave never acks, m0 keeps cyc high through the err
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      check($sformatf("s4_err_k%0d", k), m0_err, (k == 8));
      check($sformatf("s4_s_cyc_k%0d", k), s_cyc, (k < 8 || k == 10));
      check($sformatf("s4_grant_k%0d", k), grant, (k < 8 || k == 10) ? 2'b01 : 2'b00);
      if (k == 9) check("s4_tcount", timeout_count, 8'd1);
    end
    release_all();
    tick();

    // Ack lands exactly on the threshold cycle
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k == 7) begin
        s_ack = 1'b1; s_dat_r = 16'hA5A5;
        #1;
        check("s5_ack", m0_ack, 1'b1);
        check("s5_dat_r", m0_dat_r, 16'hA5A5);
      end
      if (k == 8) begin
        s_ack = 1'b0;
        check("s5_grant", grant, 2'b01);
      end
      check($sformatf("s5_err_k%0d", k), m0_err, 1'b0);
    end
    check("s5_tcount", timeout_count, 8'd1);
    release_all();
    tick();

    // Reset mid-grant to m1, then m0 wins the first contention
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    tick();
    check("s6_grant", grant, 2'b10);
    check("s6_s_stb", s_stb, 1'b1);
    #2;
    reset = 1'b0; s_ack = 1'b1; m_cyc = 2'b11; m_stb = 2'b11;
    #1;
    check("s6_rst_s_cyc", s_cyc, 1'b0);
    check("s6_rst_s_stb", s_stb, 1'b0);
    check("s6_rst_grant", grant, 2'b00);
    check("s6_rst_m1_ack", m1_ack, 1'b0);
    check("s6_rst_m1_err", m1_err, 1'b0);
    check("s6_rst_tcount", timeout_count, 8'd0);
    tick();
    #2;
    reset = 1'b1; s_ack = 1'b0;
    tick();
    check("s6_after_rst", grant, 2'b01);
    s_ack = 1'b1;
    tick();
    release_all();
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, Wishbone address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, Wishbone data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, the maximum number of stalled slave cycles before an error is issued (range 2..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single FPGA clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 For each master n in {0,1}, the block SHALL have inputs mn_cyc (1), mn_stb (1), mn_we (1), mn_adr (ADDR_WIDTH) and mn_dat_w (DATA_WIDTH). Master 0 is the GPMC bridge.
REQ-007 For each master n, the block SHALL have outputs mn_dat_r (DATA_WIDTH), mn_ack (1) and mn_err (1).
REQ-008 The block SHALL have slave-side outputs s_cyc, s_stb, s_we (1 bit each), s_adr (ADDR_WIDTH) and s_dat_w (DATA_WIDTH).
REQ-009 The block SHALL have slave-side inputs s_dat_r (DATA_WIDTH) and s_ack (1 bit).
REQ-010 The block SHALL have status outputs grant (2 bits, one-hot, 00 = none) and timeout_count (8 bits, saturating).

Function
REQ-011 The block SHALL implement an FSM with four states: IDLE, GNT0, GNT1 and ERR.
REQ-012 In IDLE, the grant decision SHALL follow these rules, with the state changing on the next edge:
- only mn_cyc high: go to GNTn;
- both high: grant the master other than last_grant;
- neither high: stay in IDLE.
REQ-013 last_grant SHALL be a 1-bit register, updated when entering GNTn, and reset to 1 so that master 0 wins the first contention.
REQ-014 In GNTn, all s_* outputs SHALL be driven combinationally from master n. The other master's ack and err SHALL be 0 and its dat_r SHALL be 0.
REQ-015 In GNTn, mn_ack SHALL equal s_ack (combinational, zero added latency) and mn_dat_r SHALL equal s_dat_r.
REQ-016 In IDLE and ERR, s_cyc and s_stb SHALL be 0, s_we SHALL be 0, s_adr and s_dat_w SHALL be 0, and every mn_ack SHALL be 0.
REQ-017 GNTn SHALL be held while mn_cyc is 1. When mn_cyc is sampled 0, the FSM SHALL return to IDLE, giving one dead cycle between owners. A grant is never pre-empted.
REQ-018 A stall counter (8 bits) SHALL behave as follows:
- clear on entry to GNTn and on any cycle where s_ack = 1;
- increment on each cycle in GNTn with s_stb = 1 and s_ack = 0.
REQ-019 When the stall counter equals TIMEOUT-1 and s_ack = 0, the FSM SHALL go to ERR.
REQ-020 In ERR, mn_err SHALL be 1 for exactly one cycle to the owning master, timeout_count SHALL increment (saturating at 255), and the next state SHALL be IDLE.
REQ-021 If s_ack = 1 in the same cycle as the timeout threshold, the ack SHALL win: no ERR and the counter clears.
REQ-022 grant SHALL be 01 in GNT0, 10 in GNT1, and 00 otherwise.
REQ-023 A master that keeps cyc high after err SHALL be treated as a new request in IDLE under normal round-robin.

Reset
REQ-024 While reset = 0, the FSM SHALL be in IDLE, last_grant SHALL be 1, the stall counter and timeout_count SHALL be 0, and all outputs SHALL be 0.
REQ-025 Reset asserted mid-grant SHALL abort the cycle immediately: s_cyc drops asynchronously and no ack or err is issued.
REQ-026 Operation SHALL resume on the first clk edge after reset deasserts.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, ERR = 2'd3) and the default widths.
REQ-028 The block SHALL contain one sub-module, wb_timeout_counter, holding the stall counter and threshold compare. The FSM and muxing SHALL be in wb_arbiter_2m.

Verification
REQ-029 Directed scenario, single master: only m0 writes adr 0x0010 data 0xBEEF, slave acks after 2 cycles -> s_adr = 0x0010, s_dat_w = 0xBEEF, s_we = 1, m0_ack pulses once, grant = 01, m1_ack = 0.
REQ-030 Directed scenario, contention: m0 and m1 raise cyc in the same cycle after reset -> m0 is granted first. After m0 drops cyc there is one IDLE cycle, then grant = 10.
REQ-031 Directed scenario, round-robin: both masters request continuously for 4 transactions -> the grant sequence is 01, 10, 01, 10.
REQ-032 Directed scenario, timeout: TIMEOUT = 8, slave never acks -> m0_err is high exactly one cycle, 8 cycles after grant entry; timeout_count = 1; s_cyc = 0 during ERR.
REQ-033 Directed scenario, boundary: slave acks on the threshold cycle -> no err, ack passed through, timeout_count unchanged.
REQ-034 Directed scenario, mid-operation reset: reset pulled low while grant = 10 with s_stb = 1 -> all outputs are 0 asynchronously; after release, the state is IDLE and m0 has priority.
